// File: rtl/sprite_palette_arbiter.sv
// Sprite palette arbiter: two sprite pixel requesters share one combinational
// 16-entry palette. Round-robin grant, index register then RGB register,
// valid/ready backpressure, and a transparent-key flag for the compositor.
module sprite_palette_arbiter #(
    parameter int          TAG_W        = 10,
    parameter logic [3:0]  TRANSP_INDEX = 4'd1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             req0_valid,
    input  logic [3:0]       req0_index,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_index,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_ready,
    output logic [3:0]       pal_index,
    input  logic [3:0]       pal_red,
    input  logic [3:0]       pal_green,
    input  logic [3:0]       pal_blue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag,
    output logic [11:0]      out_rgb,
    output logic             out_transparent
);

    logic             s1_valid;
    logic             s1_src;
    logic [3:0]       s1_index;
    logic [TAG_W-1:0] s1_tag;
    logic             last_grant;
    logic             stall;
    logic             s1_en;
    logic             grant0;
    logic             grant1;

    function automatic logic is_transp(input logic [3:0] idx);
        return idx == TRANSP_INDEX;
    endfunction

    // A full output register that downstream refuses freezes the whole pipe.
    assign stall = out_valid & ~out_ready;
    assign s1_en = ~stall;

    // last_grant=1 means requester 1 won last, so requester 0 wins a tie next.
    assign grant0 = s1_en & req0_valid & (~req1_valid | last_grant);
    assign grant1 = s1_en & req1_valid & (~req0_valid | ~last_grant);

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign pal_index  = s1_index;

    // Stage 1: capture the granted pixel and remember who won.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid   <= 1'b0;
            s1_src     <= 1'b0;
            s1_index   <= 4'd0;
            s1_tag     <= '0;
            last_grant <= 1'b1;
        end else if (s1_en) begin
            s1_valid <= grant0 | grant1;
            if (grant0) begin
                s1_src     <= 1'b0;
                s1_index   <= req0_index;
                s1_tag     <= req0_tag;
                last_grant <= 1'b0;
            end else if (grant1) begin
                s1_src     <= 1'b1;
                s1_index   <= req1_index;
                s1_tag     <= req1_tag;
                last_grant <= 1'b1;
            end
        end
    end

    // Stage 2: register the palette response and transparency key.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid       <= 1'b0;
            out_src         <= 1'b0;
            out_tag         <= '0;
            out_rgb         <= 12'd0;
            out_transparent <= 1'b0;
        end else if (!stall) begin
            out_valid       <= s1_valid;
            out_src         <= s1_src;
            out_tag         <= s1_tag;
            out_rgb         <= {pal_red, pal_green, pal_blue};
            out_transparent <= is_transp(s1_index);
        end
    end

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Bench for sprite_palette_arbiter: random requesters with hold-until-accepted
// behaviour, a palette model, and a scoreboard checked by a separate monitor.
module tb_sprite_palette_arbiter;

    localparam int         TAG_W  = 10;
    localparam logic [3:0] TRANSP = 4'd1;

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic             req0_valid, req1_valid;
    logic [3:0]       req0_index, req1_index;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             req0_ready, req1_ready;
    logic [3:0]       pal_index, pal_red, pal_green, pal_blue;
    logic             out_valid, out_ready, out_src, out_transparent;
    logic [TAG_W-1:0] out_tag;
    logic [11:0]      out_rgb;

    always #5 Clk = ~Clk;

    sprite_palette_arbiter #(.TAG_W(TAG_W), .TRANSP_INDEX(TRANSP)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req0_valid(req0_valid), .req0_index(req0_index), .req0_tag(req0_tag), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_index(req1_index), .req1_tag(req1_tag), .req1_ready(req1_ready),
        .pal_index(pal_index), .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_tag(out_tag),
        .out_rgb(out_rgb), .out_transparent(out_transparent)
    );

    // Palette contents (reference table shared with the expected-value model)
    logic [11:0] palette [16];
    initial begin
        for (int i = 0; i < 16; i++) palette[i] = 12'((i * 12'h2B7) ^ 12'h5A3);
        palette[0]  = 12'h000;
        palette[1]  = 12'hF0F;
        palette[2]  = 12'hEED;
        palette[4]  = 12'hC84;
        palette[12] = 12'hFFF;
    end

    always_comb begin
        pal_red   = palette[pal_index][11:8];
        pal_green = palette[pal_index][7:4];
        pal_blue  = palette[pal_index][3:0];
    end

    logic [23:0] sb_q [$];
    int n_cmp = 0;
    int n_err = 0;

    // Driver knobs
    int p0 = 0, p1 = 0, pr = 100;
    int idx0_fix = -1, idx1_fix = -1, tag_fix = -1;
    logic acc0 = 1'b0, acc1 = 1'b0;
    int model_last = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] mk(input logic src, input logic [TAG_W-1:0] tag, input logic [3:0] idx);
        return {src, tag, palette[idx], (idx == TRANSP)};
    endfunction

    // One clock cycle of stimulus, ready checking and scoreboard pushes
    task automatic step();
        logic stall, e0, e1;
        @(negedge Clk);
        if (!req0_valid || acc0) begin
            req0_valid = ($urandom_range(99) < p0);
            req0_index = (idx0_fix >= 0) ? 4'(idx0_fix) : 4'($urandom);
            req0_tag   = (tag_fix >= 0) ? TAG_W'(tag_fix) : TAG_W'($urandom);
        end
        if (!req1_valid || acc1) begin
            req1_valid = ($urandom_range(99) < p1);
            req1_index = (idx1_fix >= 0) ? 4'(idx1_fix) : 4'($urandom);
            req1_tag   = (tag_fix >= 0) ? TAG_W'(tag_fix) : TAG_W'($urandom);
        end
        out_ready = ($urandom_range(99) < pr);
        #1;
        stall = out_valid && !out_ready;
        e0 = !stall && req0_valid && (!req1_valid || model_last == 1);
        e1 = !stall && req1_valid && (!req0_valid || model_last == 0);
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (acc0) sb_q.push_back(mk(1'b0, req0_tag, req0_index));
        if (acc1) sb_q.push_back(mk(1'b1, req1_tag, req1_index));
        if (e0) model_last = 0;
        else if (e1) model_last = 1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        acc0 = 1'b0; acc1 = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        model_last = 1;
        sb_q.delete();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on each output handshake, checks stall hold
    logic        stall_prev = 1'b0;
    logic [24:0] prev_out;
    always @(negedge Clk) begin
        logic [24:0] cur;
        #2;
        cur = {out_valid, out_src, out_tag, out_rgb, out_transparent};
        if (Reset_n) begin
            if (stall_prev) chk("stall_hold", 32'(cur), 32'(prev_out));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL out_pixel: got %0h, expected no pixel (scoreboard empty)", cur[23:0]);
                end else begin
                    chk("out_pixel", 32'(cur[23:0]), 32'(sb_q.pop_front()));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = cur;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        Reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_index = 4'd0; req1_index = 4'd0;
        req0_tag = '0; req1_tag = '0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_src", 32'(out_src), 0);
        chk("rst_out_tag", 32'(out_tag), 0);
        chk("rst_out_rgb", 32'(out_rgb), 0);
        chk("rst_out_transp", 32'(out_transparent), 0);
        chk("rst_pal_index", 32'(pal_index), 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        // Single source: index 4, tag 100, latency 2
        p0 = 100; idx0_fix = 4; tag_fix = 100;
        step();
        p0 = 0;
        step();
        chk("lat_c1_valid", 32'(out_valid), 0);
        step();
        chk("lat_c2_valid", 32'(out_valid), 1);
        chk("lat_c2_src", 32'(out_src), 0);
        chk("lat_c2_tag", 32'(out_tag), 100);
        chk("lat_c2_rgb", 32'(out_rgb), 32'h0C84);
        chk("lat_c2_transp", 32'(out_transparent), 0);
        tag_fix = -1;
        repeat (3) step();

        // Transparency: requester 1 index 1, then requester 0 index 0
        p1 = 100; idx1_fix = 1;
        step();
        p1 = 0;
        step(); step();
        chk("transp_rgb", 32'(out_rgb), 32'h0F0F);
        chk("transp_flag", 32'(out_transparent), 1);
        p0 = 100; idx0_fix = 0;
        step();
        p0 = 0;
        step(); step();
        chk("idx0_rgb", 32'(out_rgb), 32'h0000);
        chk("idx0_flag", 32'(out_transparent), 0);
        repeat (3) step();

        // Contention: both valid, indices 2 and 12, full throughput
        do_reset();
        p0 = 100; p1 = 100; idx0_fix = 2; idx1_fix = 12; pr = 100;
        repeat (2) step();
        repeat (6) begin
            step();
            chk("thru_valid", 32'(out_valid), 1);
        end

        // Backpressure: three refused cycles with a full pipe, then release
        pr = 0;
        repeat (3) step();
        pr = 100;
        repeat (6) step();

        // Reset mid-stream with both stages valid
        #2;
        Reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_pal_index", 32'(pal_index), 0);
        acc0 = 1'b0; acc1 = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        model_last = 1;
        sb_q.delete();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (8) step();

        // Random traffic with idle gaps and random backpressure
        idx0_fix = -1; idx1_fix = -1;
        p0 = 50; p1 = 50; pr = 70;
        repeat (1000) step();

        // Drain
        p0 = 0; p1 = 0; pr = 100;
        repeat (10) step();
        chk("drain_empty", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_palette_arbiter.md
Name: sprite_palette_arbiter

Overview:
- Shares one combinational 16-entry sprite palette lookup (4-bit index in, 12-bit RGB out) between two sprite pixel requesters, e.g. player 1 and player 2 draw engines.
- Round-robin arbitration; 2-stage pipeline (index register, RGB register) with valid/ready backpressure; flags transparent pixels for the frame compositor downstream.
- Sits between the sprite ROM readers and the VGA line compositor.

Parameters:
- TAG_W, 10, width of per-pixel tag (screen x coordinate) carried alongside the index
- TRANSP_INDEX, 1, palette index treated as transparent (magenta key colour)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 presents a pixel
- req0_index  in  4  requester 0 palette index
- req0_tag  in  TAG_W  requester 0 tag
- req0_ready  out  1  requester 0 pixel accepted this cycle
- req1_valid, req1_index, req1_tag, req1_ready  same as requester 0, for requester 1
- pal_index  out  4  index driven to the shared palette
- pal_red, pal_green, pal_blue  in  4 each  palette response, combinational from pal_index
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts output
- out_src  out  1  requester that issued the pixel (0/1)
- out_tag  out  TAG_W  tag of the pixel
- out_rgb  out  12  {red,green,blue} from the palette
- out_transparent  out  1  1 when the pixel's index == TRANSP_INDEX

Behaviour:
- Reset (async, Reset_n=0): s1_valid=0, out_valid=0, out_src=0, out_tag=0, out_rgb=0, out_transparent=0, pal_index=0, last_grant=1, so requester 0 wins the first contention. Reset mid-stream drops all in-flight pixels with no output.
- Stage 1 registers: s1_valid, s1_src, s1_index, s1_tag. pal_index = s1_index, combinationally.
- Stage 2 registers: the out_* signals. out_rgb is the palette response to s1_index; out_transparent = (s1_index == TRANSP_INDEX).
- Stall: stall = out_valid & ~out_ready.
  - s2 loads when ~stall. It loads s1 contents; out_valid takes s1_valid.
  - s1 advances (s1_en) when ~stall.
  - When stall=1, both stages hold and no requester is accepted.
- Arbitration happens only when s1_en=1:
  - Only one request valid: that requester is granted.
  - Both valid: grant goes to ~last_grant. last_grant updates only on an actual grant.
  - Neither valid: s1 loads s1_valid=0.
- Granted requester gets reqN_ready=1 in the same cycle. reqN_ready is combinational from valid, last_grant and stall, and at most one ready is high per cycle. A transfer occurs when reqN_valid & reqN_ready.
- Ungranted requester must hold valid, index and tag stable until accepted.
- Latency: request accepted in cycle N gives out_valid in cycle N+2 when not stalled. Throughput is 1 pixel/cycle total.
- Each stall cycle adds one cycle of latency. Nothing is dropped or duplicated.
- Ordering: pixels from the same requester leave in acceptance order. Interleaving between requesters follows grant order.
- Transparent pixels still pass through with their palette RGB. Discarding them is the compositor's job.

Test Plan:
- Reset then single source: req0 index 4, tag 100 -> req0_ready=1 at cycle 0; cycle 2: out_valid=1, src=0, tag=100, out_rgb = palette[4] (C84), transparent=0.
- Contention: both valid continuously, indices 2 and 12 -> grants alternate 0,1,0,1 starting with 0; outputs alternate EED/FFF, one pixel per cycle.
- Transparency: req1 index 1 -> out_rgb=F0F, out_transparent=1. Index 0 -> rgb 000, transparent=0.
- Backpressure: hold out_ready=0 for 3 cycles with a full pipeline -> both readys 0, out_* unchanged. Release -> the held pixels emerge in order, then the next grant; no loss or duplication.
- Reset mid-stream: assert Reset_n=0 while both stages are valid -> out_valid=0 immediately (async). After release, the first contention grants requester 0.
- Idle gaps: random valid on both requesters against a scoreboard over 1000 cycles -> every accepted pixel appears once, with correct src, tag and rgb, and per-source order is preserved.
